// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline requester A vs. a 2-entry FIFO for the long-latency unit B.
// Define WB_RR_EN for round-robin arbitration; the default build uses fixed priority with A winning.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  output logic        p_ready,
  input  logic        l_valid,
  input  logic [4:0]  l_addr,
  input  logic [31:0] l_data,
  output logic        l_ready,
  output logic        w_regs_en,
  output logic [4:0]  w_regs_addr,
  output logic [31:0] w_regs_data,
  input  logic [4:0]  q_addr,
  output logic        q_hit,
  output logic [1:0]  l_cnt
);

  logic [4:0]  fifo_addr_r [2];
  logic [31:0] fifo_data_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  cnt_r;
  logic        w_en_r;
  logic [4:0]  w_addr_r;
  logic [31:0] w_data_r;

  logic        b_avail_s;
  logic        a_first_s;
  logic        grant_a_s;
  logic        grant_b_s;
  logic        push_s;
  logic [4:0]  win_addr_s;
  logic [31:0] win_data_s;
  logic        q_hit_s;

  assign b_avail_s   = (cnt_r != 2'd0);
  assign l_ready     = (cnt_r != 2'd2);
  assign push_s      = l_valid && l_ready;
  assign p_ready     = grant_a_s;
  assign l_cnt       = cnt_r;
  assign w_regs_en   = w_en_r;
  assign w_regs_addr = w_addr_r;
  assign w_regs_data = w_data_r;
  assign q_hit       = q_hit_s;

`ifdef WB_RR_EN
  logic rr_prio_b_r;

  assign a_first_s = !rr_prio_b_r;

  // Round-robin pointer: only a contended grant hands priority to the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_prio_b_r <= 1'b0;
    end else if (p_valid && b_avail_s) begin
      rr_prio_b_r <= grant_a_s;
    end else begin
      rr_prio_b_r <= rr_prio_b_r;
    end
  end
`else
  assign a_first_s = 1'b1;
`endif

  // Select the single winner for this cycle and its payload.
  always_comb begin
    grant_a_s  = 1'b0;
    grant_b_s  = 1'b0;
    win_addr_s = fifo_addr_r[rd_ptr_r];
    win_data_s = fifo_data_r[rd_ptr_r];
    if (p_valid && (!b_avail_s || a_first_s)) begin
      grant_a_s  = 1'b1;
      win_addr_s = p_addr;
      win_data_s = p_data;
    end else if (b_avail_s) begin
      grant_b_s = 1'b1;
    end else begin
      grant_b_s = 1'b0;
    end
  end

  // B request FIFO; 1-bit pointers wrap naturally over the two slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_addr_r <= '{5'd0, 5'd0};
      fifo_data_r <= '{32'd0, 32'd0};
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      cnt_r       <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= l_addr;
        fifo_data_r[wr_ptr_r] <= l_data;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (grant_b_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, grant_b_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Registered write port; x0 targets are consumed but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en_r   <= 1'b0;
      w_addr_r <= 5'd0;
      w_data_r <= 32'd0;
    end else if (grant_a_s || grant_b_s) begin
      w_en_r   <= (win_addr_s != 5'd0);
      w_addr_r <= win_addr_s;
      w_data_r <= win_data_s;
    end else begin
      w_en_r   <= 1'b0;
    end
  end

  // Pending-write lookup over live FIFO slots and the in-flight output.
  always_comb begin
    q_hit_s = 1'b0;
    if (q_addr == 5'd0) begin
      q_hit_s = 1'b0;
    end else if (w_en_r && (w_addr_r == q_addr)) begin
      q_hit_s = 1'b1;
    end else if ((cnt_r != 2'd0) && (fifo_addr_r[rd_ptr_r] == q_addr)) begin
      q_hit_s = 1'b1;
    end else if ((cnt_r == 2'd2) && (fifo_addr_r[~rd_ptr_r] == q_addr)) begin
      q_hit_s = 1'b1;
    end else begin
      q_hit_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; the contention expectations follow WB_RR_EN.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        p_ready;
  logic        l_valid;
  logic [4:0]  l_addr;
  logic [31:0] l_data;
  logic        l_ready;
  logic        w_regs_en;
  logic [4:0]  w_regs_addr;
  logic [31:0] w_regs_data;
  logic [4:0]  q_addr;
  logic        q_hit;
  logic [1:0]  l_cnt;

  int passed;
  int total;

  logic [4:0]  exp_pr;
  logic [4:0]  exp_addr [5];
  logic [31:0] exp_data [5];
  logic [1:0]  exp_cnt  [5];
  logic [2:0]  drn_en;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_ready(p_ready),
    .l_valid(l_valid), .l_addr(l_addr), .l_data(l_data), .l_ready(l_ready),
    .w_regs_en(w_regs_en), .w_regs_addr(w_regs_addr), .w_regs_data(w_regs_data),
    .q_addr(q_addr), .q_hit(q_hit), .l_cnt(l_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; p_valid = 1'b0; l_valid = 1'b0;
    p_addr = 5'd0; p_data = 32'd0; l_addr = 5'd0; l_data = 32'd0; q_addr = 5'd0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; p_valid = 1'b0; l_valid = 1'b0; q_addr = 5'd3;
    #1;
    total++; if ({w_regs_en, w_regs_addr, w_regs_data} !== 38'd0) $display("FAIL reset_wport got %b/%0d/%h want 0/0/0", w_regs_en, w_regs_addr, w_regs_data); else passed++;
    total++; if (l_cnt !== 2'd0) $display("FAIL reset_lcnt got %0d want 0", l_cnt); else passed++;
    total++; if ({l_ready, p_ready, q_hit} !== 3'b100) $display("FAIL reset_flags got %b want 100", {l_ready, p_ready, q_hit}); else passed++;
    @(negedge clk);
    rst = 1'b0; q_addr = 5'd0;
  endtask

  task automatic test_a_alone();
    @(negedge clk);
    p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h11;
    #1;
    total++; if (p_ready !== 1'b1) $display("FAIL a_alone_pready got %b want 1", p_ready); else passed++;
    @(posedge clk); #1;
    total++; if ({w_regs_en, w_regs_addr, w_regs_data} !== {1'b1, 5'd5, 32'h11}) $display("FAIL a_alone_write got %b/%0d/%h want 1/5/11", w_regs_en, w_regs_addr, w_regs_data); else passed++;
    @(negedge clk);
    p_valid = 1'b0;
    @(posedge clk); #1;
    total++; if ({w_regs_en, w_regs_addr, w_regs_data} !== {1'b0, 5'd5, 32'h11}) $display("FAIL idle_hold got %b/%0d/%h want 0/5/11", w_regs_en, w_regs_addr, w_regs_data); else passed++;
  endtask

  task automatic test_contention();
    logic [31:0] a_seq;
`ifdef WB_RR_EN
    exp_pr = 5'b01011;
    exp_addr = '{5'd9, 5'd9, 5'd1, 5'd9, 5'd2};
    exp_data = '{32'hA0, 32'hA1, 32'hB1, 32'hA2, 32'hB2};
    exp_cnt  = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
    drn_en   = 3'b000;
`else
    exp_pr = 5'b11111;
    exp_addr = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd9};
    exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    exp_cnt  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    drn_en   = 3'b011;
`endif
    do_reset();
    a_seq = 32'hA0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      p_valid = 1'b1; p_addr = 5'd9; p_data = a_seq;
      l_valid = (i < 3); l_addr = 5'(i + 1); l_data = 32'hB0 + 32'(i + 1);
      #1;
      total++; if (p_ready !== exp_pr[i]) $display("FAIL cont_pready[%0d] got %b want %b", i, p_ready, exp_pr[i]); else passed++;
      if (i == 2) begin
        total++; if (l_ready !== 1'b0) $display("FAIL cont_lready_full got %b want 0", l_ready); else passed++;
      end
      if (exp_pr[i]) a_seq = a_seq + 32'd1;
      @(posedge clk); #1;
      total++; if ({w_regs_en, w_regs_addr, w_regs_data} !== {1'b1, exp_addr[i], exp_data[i]})
        $display("FAIL cont_write[%0d] got %b/%0d/%h want 1/%0d/%h", i, w_regs_en, w_regs_addr, w_regs_data, exp_addr[i], exp_data[i]); else passed++;
      total++; if (l_cnt !== exp_cnt[i]) $display("FAIL cont_lcnt[%0d] got %0d want %0d", i, l_cnt, exp_cnt[i]); else passed++;
    end
    @(negedge clk);
    p_valid = 1'b0; l_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      total++; if (w_regs_en !== drn_en[j]) $display("FAIL drain_en[%0d] got %b want %b", j, w_regs_en, drn_en[j]); else passed++;
      if (drn_en[j]) begin
        total++; if ({w_regs_addr, w_regs_data} !== {5'(j + 1), 32'hB0 + 32'(j + 1)})
          $display("FAIL drain_write[%0d] got %0d/%h want %0d/%h", j, w_regs_addr, w_regs_data, j + 1, 32'hB0 + 32'(j + 1)); else passed++;
      end
    end
    total++; if (l_cnt !== 2'd0) $display("FAIL drain_lcnt got %0d want 0", l_cnt); else passed++;
  endtask

  task automatic test_x0();
    @(negedge clk);
    p_valid = 1'b0; l_valid = 1'b1; l_addr = 5'd0; l_data = 32'hFF;
    @(posedge clk); #1;
    total++; if ({w_regs_en, l_cnt} !== {1'b0, 2'd1}) $display("FAIL x0_push got en=%b cnt=%0d want 0/1", w_regs_en, l_cnt); else passed++;
    @(negedge clk);
    l_valid = 1'b0;
    @(posedge clk); #1;
    total++; if ({w_regs_en, l_cnt} !== {1'b0, 2'd0}) $display("FAIL x0_pop got en=%b cnt=%0d want 0/0", w_regs_en, l_cnt); else passed++;
    @(negedge clk);
    p_valid = 1'b1; p_addr = 5'd0; p_data = 32'h55;
    #1;
    total++; if (p_ready !== 1'b1) $display("FAIL x0_a_pready got %b want 1", p_ready); else passed++;
    @(posedge clk); #1;
    total++; if (w_regs_en !== 1'b0) $display("FAIL x0_a_en got %b want 0", w_regs_en); else passed++;
    @(negedge clk);
    p_valid = 1'b0;
  endtask

  task automatic test_qhit();
    @(negedge clk);
    l_valid = 1'b1; l_addr = 5'd7; l_data = 32'h77;
    @(posedge clk);
    @(negedge clk);
    l_valid = 1'b0; q_addr = 5'd7;
    #1;
    total++; if (q_hit !== 1'b1) $display("FAIL qhit_fifo got %b want 1", q_hit); else passed++;
    q_addr = 5'd0; #1;
    total++; if (q_hit !== 1'b0) $display("FAIL qhit_x0 got %b want 0", q_hit); else passed++;
    q_addr = 5'd5; #1;
    total++; if (q_hit !== 1'b0) $display("FAIL qhit_other got %b want 0", q_hit); else passed++;
    q_addr = 5'd7;
    @(posedge clk); #1;
    total++; if ({w_regs_en, q_hit} !== 2'b11) $display("FAIL qhit_outreg got en=%b hit=%b want 1/1", w_regs_en, q_hit); else passed++;
    @(posedge clk); #1;
    total++; if (q_hit !== 1'b0) $display("FAIL qhit_retired got %b want 0", q_hit); else passed++;
    q_addr = 5'd0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    p_valid = 1'b1; p_addr = 5'd4; p_data = 32'h44;
    l_valid = 1'b1; l_addr = 5'd10; l_data = 32'hC0;
    @(posedge clk);
    @(negedge clk);
    p_data = 32'h45; l_addr = 5'd11; l_data = 32'hC1;
    @(posedge clk); #1;
    total++; if ({w_regs_en, l_cnt} !== {1'b1, 2'd2}) $display("FAIL mid_pre got en=%b cnt=%0d want 1/2", w_regs_en, l_cnt); else passed++;
    p_valid = 1'b0; l_valid = 1'b0; rst = 1'b1;
    #1;
    total++; if ({w_regs_en, l_cnt, l_ready, w_regs_addr} !== {1'b0, 2'd0, 1'b1, 5'd0}) $display("FAIL mid_rst got en=%b cnt=%0d rdy=%b addr=%0d want 0/0/1/0", w_regs_en, l_cnt, l_ready, w_regs_addr); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if ({w_regs_en, l_cnt} !== {1'b0, 2'd0}) $display("FAIL mid_post[%0d] got en=%b cnt=%0d want 0/0", k, w_regs_en, l_cnt); else passed++;
    end
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b1; p_valid = 1'b0; l_valid = 1'b0;
    p_addr = 5'd0; p_data = 32'd0; l_addr = 5'd0; l_data = 32'd0; q_addr = 5'd0;
    test_reset();
    test_a_alone();
    test_contention();
    test_x0();
    test_qhit();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
